// File: rtl/loproc_alu_seq.sv
// Sequencer that drives an external combinational ALU to execute 32-bit ops in one
// pass and 64-bit ADD64/SUB64 as a low/high pair with a chained carry.
//
// state   | meaning
// IDLE    | req_ready high, waiting for a request
// EXEC_LO | low operand words on the ALU, capture at clock end
// EXEC_HI | high operand words on the ALU with low-word carry chained in
// RESP    | rsp_* held until the consumer takes them
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module loproc_alu_seq (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [3:0]               req_op,
  input  logic [2*`DATA_WIDTH-1:0] req_a,
  input  logic [2*`DATA_WIDTH-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [2*`DATA_WIDTH-1:0] rsp_result,
  output logic                     rsp_carry,
  output logic                     rsp_zero,
  output logic                     rsp_err,
  output logic [`DATA_WIDTH-1:0]   alu_x,
  output logic [`DATA_WIDTH-1:0]   alu_y,
  output logic                     alu_zx,
  output logic                     alu_zy,
  output logic                     alu_nx,
  output logic                     alu_ny,
  output logic                     alu_f,
  output logic                     alu_l,
  output logic                     alu_cs,
  output logic                     alu_asel,
  output logic                     alu_cin,
  input  logic [`DATA_WIDTH-1:0]   alu_out,
  input  logic                     alu_cout
);
  localparam int W = `DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, EXEC_LO, EXEC_HI, RESP} state_t;
  typedef struct packed {
    logic zx, zy, nx, ny, f, l, cs, asel;
  } ctl_t;

  state_t         state;
  ctl_t           ctl_q;
  logic [3:0]     op_q;
  logic [W-1:0]   a_hi, b_hi, lo_q;
  logic           carry_flag;
  logic [2*W-1:0] fin_result;
  logic           fin_carry;

  function automatic ctl_t decode(input logic [3:0] op);
    ctl_t c;
    c = '0;
    case (op)
      4'd0:  c.f = 1'b1;
      4'd1:  begin c.ny = 1'b1; c.f = 1'b1; c.cs = 1'b1; end
      4'd3:  begin c.nx = 1'b1; c.ny = 1'b1; c.asel = 1'b1; end
      4'd4:  c.l = 1'b1;
      4'd5:  begin c.zy = 1'b1; c.l = 1'b1; c.asel = 1'b1; end
      4'd6:  begin c.f = 1'b1; c.cs = 1'b1; end
      4'd7:  c.f = 1'b1;
      4'd8:  begin c.ny = 1'b1; c.f = 1'b1; c.cs = 1'b1; end
      4'd9:  begin c.zy = 1'b1; c.l = 1'b1; end
      4'd10: begin c.zy = 1'b1; c.nx = 1'b1; c.f = 1'b1; c.cs = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic is_arith(input logic [3:0] op);
    return (op == 4'd0) || (op == 4'd1) || (op == 4'd6) ||
           (op == 4'd7) || (op == 4'd8) || (op == 4'd10);
  endfunction

  function automatic logic is_wide(input logic [3:0] op);
    return (op == 4'd7) || (op == 4'd8);
  endfunction

  assign {alu_zx, alu_zy, alu_nx, alu_ny, alu_f, alu_l, alu_cs, alu_asel} = ctl_q;

  // Illegal opcodes still run the ALU pass but their result is discarded.
  always_comb begin
    fin_result = '0;
    if (state == EXEC_HI)
      fin_result = {alu_out, lo_q};
    else if (op_q <= 4'd10)
      fin_result = {{W{1'b0}}, alu_out};
    fin_carry = is_arith(op_q) & alu_cout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
      carry_flag <= 1'b0;
      alu_x      <= '0;
      alu_y      <= '0;
      alu_cin    <= 1'b0;
      ctl_q      <= '0;
      op_q       <= '0;
      a_hi       <= '0;
      b_hi       <= '0;
      lo_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q      <= req_op;
            a_hi      <= req_a[2*W-1:W];
            b_hi      <= req_b[2*W-1:W];
            alu_x     <= req_a[W-1:0];
            alu_y     <= req_b[W-1:0];
            ctl_q     <= decode(req_op);
            alu_cin   <= (req_op == 4'd1) || (req_op == 4'd8) || (req_op == 4'd10) ||
                         ((req_op == 4'd6) && carry_flag);
            req_ready <= 1'b0;
            state     <= EXEC_LO;
          end
        end
        EXEC_LO, EXEC_HI: begin
          if (state == EXEC_LO && is_wide(op_q)) begin
            lo_q     <= alu_out;
            alu_x    <= a_hi;
            alu_y    <= b_hi;
            ctl_q.cs <= 1'b1;
            alu_cin  <= alu_cout;
            state    <= EXEC_HI;
          end else begin
            rsp_result <= fin_result;
            rsp_carry  <= fin_carry;
            rsp_zero   <= (fin_result == '0);
            rsp_err    <= (op_q > 4'd10);
            if (is_arith(op_q))
              carry_flag <= alu_cout;
            rsp_valid  <= 1'b1;
            alu_x      <= '0;
            alu_y      <= '0;
            alu_cin    <= 1'b0;
            ctl_q      <= '0;
            state      <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_loproc_alu_seq.sv
// Bench for loproc_alu_seq: a behavioural ALU device answers the sequencer, and an
// op-level arithmetic model predicts every response.
module tb_loproc_alu_seq;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           req_valid = 1'b0, req_ready;
  logic [3:0]     req_op = '0;
  logic [2*W-1:0] req_a = '0, req_b = '0;
  logic           rsp_valid, rsp_ready = 1'b0;
  logic [2*W-1:0] rsp_result;
  logic           rsp_carry, rsp_zero, rsp_err;
  logic [W-1:0]   alu_x, alu_y, alu_out;
  logic           alu_zx, alu_zy, alu_nx, alu_ny, alu_f, alu_l, alu_cs, alu_asel, alu_cin;
  logic           alu_cout;

  int n_chk = 0, n_pass = 0;
  logic cf = 1'b0;

  always #5 clk = ~clk;

  loproc_alu_seq dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_x(alu_x), .alu_y(alu_y), .alu_zx(alu_zx), .alu_zy(alu_zy), .alu_nx(alu_nx),
    .alu_ny(alu_ny), .alu_f(alu_f), .alu_l(alu_l), .alu_cs(alu_cs), .alu_asel(alu_asel),
    .alu_cin(alu_cin), .alu_out(alu_out), .alu_cout(alu_cout)
  );

  // ALU device: zero/negate each input, then add (with gated carry-in) or
  // and/xor with optional output inversion.
  logic [W-1:0] ax, ay, lg;
  logic [W:0]   sum;
  always_comb begin
    ax = alu_zx ? '0 : alu_x;
    if (alu_nx) ax = ~ax;
    ay = alu_zy ? '0 : alu_y;
    if (alu_ny) ay = ~ay;
    sum = {1'b0, ax} + {1'b0, ay} + {{W{1'b0}}, alu_cs & alu_cin};
    lg  = alu_l ? (ax ^ ay) : (ax & ay);
    if (alu_f) begin
      alu_out  = sum[W-1:0];
      alu_cout = sum[W];
    end else begin
      alu_out  = alu_asel ? ~lg : lg;
      alu_cout = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] r, output logic c, output logic e);
    logic [31:0] x, y;
    logic [32:0] s;
    logic [64:0] s64;
    x = a[31:0];
    y = b[31:0];
    r = '0; c = 1'b0; e = 1'b0;
    case (op)
      4'd0:  begin s = {1'b0, x} + {1'b0, y}; r = {32'b0, s[31:0]}; c = s[32]; end
      4'd1:  begin r = {32'b0, x - y}; c = (x >= y); end
      4'd2:  r = {32'b0, x & y};
      4'd3:  r = {32'b0, x | y};
      4'd4:  r = {32'b0, x ^ y};
      4'd5:  r = {32'b0, ~x};
      4'd6:  begin s = {1'b0, x} + {1'b0, y} + {32'b0, cf}; r = {32'b0, s[31:0]}; c = s[32]; end
      4'd7:  begin s64 = {1'b0, a} + {1'b0, b}; r = s64[63:0]; c = s64[64]; end
      4'd8:  begin r = a - b; c = (a >= b); end
      4'd9:  r = {32'b0, x};
      4'd10: begin r = {32'b0, ~x + 32'd1}; c = (x == 32'd0); end
      default: e = 1'b1;
    endcase
    if (op inside {4'd0, 4'd1, 4'd6, 4'd7, 4'd8, 4'd10}) cf = c;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic do_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       input int hold);
    logic [63:0] er;
    logic        ec, ee, lo_c, wide;
    logic [32:0] t;
    int          n;
    wide = (op == 4'd7) || (op == 4'd8);
    t = {1'b0, a[31:0]} + {1'b0, b[31:0]};
    lo_c = (op == 4'd8) ? (a[31:0] >= b[31:0]) : t[32];
    model(op, a, b, er, ec, ee);
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1; rsp_ready = (hold == 0);
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk("accept_ready", req_ready, 1);
    @(negedge clk);
    if (hold == 0) req_valid = 1'b0;
    chk("lo_alu_x", alu_x, {32'b0, a[31:0]});
    chk("lo_busy", req_ready, 0);
    n = 1;
    if (wide) begin
      @(negedge clk);
      n = 2;
      chk("hi_cs", alu_cs, 1);
      chk("hi_cin", alu_cin, lo_c);
      chk("hi_alu_y", alu_y, {32'b0, b[63:32]});
    end
    while (!rsp_valid && n < 10) begin @(negedge clk); n++; end
    chk("latency", 64'(n), wide ? 64'd3 : 64'd2);
    chk("result", rsp_result, er);
    chk("carry", rsp_carry, ec);
    chk("zero", rsp_zero, (er == 64'd0));
    chk("err", rsp_err, ee);
    chk("resp_alu_idle", {alu_x, alu_f, alu_cs, alu_cin}, '0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_result", rsp_result, er);
      chk("hold_carry", rsp_carry, ec);
      chk("hold_no_accept", req_ready, 0);
    end
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("done_valid", rsp_valid, 0);
    chk("done_ready", req_ready, 1);
  endtask

  initial begin
    logic [3:0]  op;
    logic [63:0] a, b;
    int          hold;

    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_rsp", {rsp_result, rsp_carry, rsp_zero, rsp_err}, '0);
    chk("rst_alu", {alu_x, alu_y, alu_zx, alu_zy, alu_nx, alu_ny, alu_f, alu_l, alu_cs,
                    alu_asel, alu_cin}, '0);
    rst = 1'b0;
    @(negedge clk);

    do_op(4'd0, 64'h0000_0000_FFFF_FFFF, 64'd1, 0);
    do_op(4'd7, 64'h0000_0000_FFFF_FFFF, 64'd1, 0);
    do_op(4'd1, 64'd5, 64'd7, 0);
    do_op(4'd6, 64'd1, 64'd1, 0);
    do_op(4'd3, 64'hF0, 64'h0F, 0);
    do_op(4'd10, 64'd1, 64'd0, 0);
    do_op(4'd8, 64'h1_0000_0000, 64'd1, 5);
    do_op(4'd0, 64'hFFFF_FFFF, 64'd2, 0);
    do_op(4'd12, 64'h1234, 64'h5678, 0);
    do_op(4'd6, 64'd0, 64'd0, 0);

    // Reset while the high word of an ADD64 is on the ALU.
    do_op(4'd0, 64'hFFFF_FFFF, 64'd1, 0);
    req_op = 4'd7; req_a = 64'h5_FFFF_FFFF; req_b = 64'd1; req_valid = 1'b1; rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("abort_in_hi", alu_cs, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cf = 1'b0;
    chk("abort_valid", rsp_valid, 0);
    chk("abort_ready", req_ready, 1);
    chk("abort_alu", {alu_x, alu_cs, alu_f}, '0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_quiet", rsp_valid, 0);
    end
    do_op(4'd6, 64'd0, 64'd0, 0);

    for (int k = 0; k < 150; k++) begin
      op = 4'($urandom_range(0, 15));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) b = a;
      if ($urandom_range(0, 5) == 0) a[31:0] = 32'hFFFF_FFFF;
      hold = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
      do_op(op, a, b, hold);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/loproc_alu_seq.md
LOPROC_ALU_SEQ -- requirements
Module: loproc_alu_seq

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high; ports SHALL be named clk and rst.
REQ-002 Parameter: none; word width W SHALL be `DATA_WIDTH (32) from loproc_defines.vh.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  request accepted when high with req_valid.
REQ-007 req_op  in  4  opcode (see REQ-020).
REQ-008 req_a, req_b  in  2W each  operands; 32-bit ops use bits [W-1:0] only.
REQ-009 rsp_valid  out  1  result available.
REQ-010 rsp_ready  in  1  consumer accepts result.
REQ-011 rsp_result  out  2W  result; upper W bits zero for 32-bit ops.
REQ-012 rsp_carry, rsp_zero, rsp_err  out  1 each  final carry, result==0, illegal opcode.
REQ-013 alu_x, alu_y  out  W each  ALU operands.
REQ-014 alu_zx, alu_zy, alu_nx, alu_ny, alu_f, alu_l, alu_cs, alu_asel, alu_cin  out  1 each  ALU controls.
REQ-015 alu_out  in  W, alu_cout  in  1  combinational ALU result and carry.

Function
REQ-016 FSM states SHALL be IDLE, EXEC_LO, EXEC_HI, RESP.
REQ-017 req_ready SHALL be 1 only in IDLE; on req_valid&req_ready, op and operands SHALL be registered and state -> EXEC_LO.
REQ-018 EXEC_LO: drive low words; capture alu_out/alu_cout at clock end; 64-bit ops -> EXEC_HI, else -> RESP.
REQ-019 EXEC_HI: drive high words with alu_cs=1, alu_cin=carry captured in EXEC_LO; capture; -> RESP.
REQ-020 Controls (unlisted bits 0): 0 ADD f; 1 SUB ny,f,cs,cin=1; 2 AND none; 3 OR nx,ny,asel; 4 XOR l; 5 NOT zy,l,asel; 6 ADDC f,cs,cin=carry flag; 7 ADD64 f (HI adds cs); 8 SUB64 ny,f,cs,cin=1 (HI cin=chained carry); 9 PASSX zy,l; 10 NEG zy,nx,f,cs,cin=1.
REQ-021 Opcodes 11-15 SHALL take the 32-bit path with all controls 0 and complete with rsp_result=0, rsp_carry=0, rsp_zero=1, rsp_err=1.
REQ-022 Latency: rsp_valid SHALL assert 2 cycles after accept for 32-bit ops, 3 cycles for ADD64/SUB64.
REQ-023 RESP: rsp_valid=1 and all rsp_* stable until rsp_valid&rsp_ready, then -> IDLE; no new request accepted in the same cycle.
REQ-024 rsp_carry SHALL be the final alu_cout for arithmetic ops (0,1,6,7,8,10), 0 for logic ops.
REQ-025 rsp_zero SHALL be 1 iff full 2W rsp_result is zero.
REQ-026 Internal carry flag SHALL update to rsp_carry on completion of arithmetic ops only; logic and illegal ops SHALL leave it unchanged.
REQ-027 Outside EXEC_LO/EXEC_HI, alu_x, alu_y and all ALU controls SHALL be 0.
REQ-028 Arithmetic SHALL wrap modulo 2^W (32-bit) or 2^2W (64-bit) with no overflow flag.

Reset
REQ-029 rst SHALL force IDLE, req_ready=1 on the following cycle, rsp_valid=0, rsp_result=0, rsp_carry/zero/err=0, carry flag=0, ALU outputs 0.
REQ-030 rst mid-operation (any state) SHALL abort the operation with no response and no flag update; rst has priority over all handshakes.

Verification
REQ-031 ADD a=0xFFFFFFFF, b=1, rsp_ready=1 -> rsp_valid 2 cycles after accept, result 0, carry 1, zero 1.
REQ-032 ADD64 a=0x00000000_FFFFFFFF, b=1 -> 3-cycle latency, result 0x00000001_00000000, carry 0, EXEC_HI cin=1.
REQ-033 SUB 5-7 -> 0xFFFFFFFE, carry 0; then ADDC 1+1 -> 2 (carry flag 0), OR 0xF0|0x0F -> 0xFF, NEG 1 -> 0xFFFFFFFF.
REQ-034 Hold rsp_ready=0 for 5 cycles with req_valid=1 -> rsp_* stable, req_ready=0, no second accept until handshake.
REQ-035 Opcode 12 -> rsp_err=1, result 0, zero 1, carry flag preserved; rst during EXEC_HI of ADD64 -> no rsp_valid, carry flag 0.
